matrix_input_loader: RTL and testbench
======================================

// Module: matrix_input_loader
// PURPOSE
//  Upstream operand stage of the matrix ALU. Accepts a command (op_code plus scalar),
//  then streams matrix elements one byte per handshake. Packs them into the 200-bit
//  matrix_a/matrix_b buses and holds them stable while the ALU and determinant unit run.
//  Pulses start on completion.
// PARAMETERS
//  ELEM_W          8     bits per matrix element (signed)
//  DIM             5     matrix dimension; DIM*DIM elements per matrix
//  TIMEOUT_CYCLES  1024  idle-cycle limit in a LOAD state (only with LOADER_TIMEOUT_EN)
// PORTS
//  clk           in   1                 system clock, all logic on rising edge
//  rst           in   1                 synchronous, active-low reset
//  cmd_valid     in   1                 command present
//  cmd_ready     out  1                 command accepted when cmd_valid && cmd_ready
//  cmd_op        in   3                 operation code (000..101 legal)
//  cmd_scalar    in   ELEM_W            signed scalar for op 100
//  cmd_err       out  1                 1-cycle pulse: illegal op dropped
//  data_valid    in   1                 element byte present
//  data_ready    out  1                 element accepted when data_valid && data_ready
//  data_in       in   ELEM_W            element, row-major order a00,a01..a44 then b00..b44
//  op_code       out  3                 latched op to ALU
//  scalar        out  ELEM_W            latched scalar to ALU
//  matrix_a      out  DIM*DIM*ELEM_W    element k at [ELEM_W*k +: ELEM_W], k = row*DIM+col
//  matrix_b      out  DIM*DIM*ELEM_W    same packing as matrix_a
//  start         out  1                 1-cycle pulse: operands complete
//  operands_valid out 1                 high for the whole of DONE
//  result_ack    in   1                 consumer done; releases DONE
//  timeout_err   out  1                 1-cycle pulse on watchdog abort (macro only)
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE, elem counter 0. All outputs 0: matrices,
//    op_code, scalar, start, operands_valid, cmd_err, timeout_err, data_ready.
//    cmd_ready = 1 from the first cycle after reset.
//  - Reset mid-load or mid-DONE aborts at that edge. Partial data is discarded (cleared).
//  - States: IDLE -> LOAD_A -> [LOAD_B] -> DONE -> IDLE.
//  - cmd_ready = (state==IDLE); data_ready = (state in LOAD_A/LOAD_B). Both registered,
//    decoded from the state.
//  - IDLE, cmd accepted with op<=101:
//    - latch op_code and scalar; counter cleared; go to LOAD_A.
//    - if op is not 000/001, matrix_b is cleared to 0 at the same edge.
//  - IDLE, cmd accepted with op 110/111: cmd_err=1 for one cycle; state stays IDLE;
//    latched values unchanged.
//  - LOAD_x: each accepted byte is written to slot counter of that matrix; counter++.
//    - On the byte with counter==DIM*DIM-1, counter wraps to 0 at the same edge.
//    - LOAD_A then goes to LOAD_B if op is 000/001, else to DONE.
//    - LOAD_B goes to DONE.
//  - Entering DONE: start=1 and operands_valid=1 in the cycle after the last-byte edge.
//    This is 1 cycle latency. start is low from the next cycle on.
//  - DONE: operands held stable. result_ack=1 causes IDLE at the next edge.
//    operands_valid drops there; matrix/op registers keep their values.
//  - result_ack outside DONE, cmd_valid outside IDLE, data_valid outside LOAD: ignored.
//  - Back-to-back: a command may be accepted in the first IDLE cycle after DONE.
//  - No arithmetic on elements; bytes are stored bit-exact (signed interpretation downstream).
// CONFIGURATION
//  LOADER_TIMEOUT_EN defined:
//    - a counter runs in LOAD_A/LOAD_B, cleared on each accepted byte and on state entry.
//    - reaching TIMEOUT_CYCLES -> IDLE, timeout_err=1 for one cycle, matrices cleared to 0.
//  LOADER_TIMEOUT_EN undefined: no watchdog; LOAD waits indefinitely; timeout_err tied 0.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles mid-LOAD_A -> all outputs 0, state IDLE, cmd_ready=1.
//  2 op=000, A bytes 1..25, B bytes all 0xFF:
//    - matrix_a[7:0]=1, matrix_a[199:192]=25, matrix_b all 1s.
//    - start pulses exactly once, 1 cycle after the 50th byte.
//  3 op=100, scalar=-3, 25 A bytes:
//    - no LOAD_B; matrix_b==0; scalar==8'hFD.
//    - start 1 cycle after the 25th byte; further data_valid ignored (data_ready=0).
//  4 op=111 -> cmd_err one-cycle pulse, state stays IDLE. Then op=101 is accepted normally.
//  5 data_valid toggling every other cycle during LOAD:
//    - only handshaken bytes are stored, in order.
//    - result_ack held 4 cycles late -> operands_valid stays 1 until the edge after ack.
//  6 (LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16) stall 16 cycles after byte 10 of A
//    -> timeout_err pulse, IDLE, matrix_a==0.

Source files
------------

// File: rtl/matrix_input_loader.sv
// matrix_input_loader: operand front end of the matrix ALU.
// Takes one command (op + scalar), then streams DIM*DIM signed elements per matrix,
// one per data handshake, packed row-major into matrix_a / matrix_b. The operands
// are held stable in DONE until result_ack; start pulses once when they are complete.
// Optional feature macro: LOADER_TIMEOUT_EN adds a load-phase idle watchdog that
// aborts to IDLE, clears both matrices and pulses timeout_err.
module matrix_input_loader #(
    parameter int ELEM_W         = 8,
    parameter int DIM            = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [2:0]                     cmd_op,
    input  logic signed [ELEM_W-1:0]       cmd_scalar,
    output logic                           cmd_err,
    input  logic                           data_valid,
    output logic                           data_ready,
    input  logic signed [ELEM_W-1:0]       data_in,
    output logic [2:0]                     op_code,
    output logic signed [ELEM_W-1:0]       scalar,
    output logic [DIM*DIM*ELEM_W-1:0]      matrix_a,
    output logic [DIM*DIM*ELEM_W-1:0]      matrix_b,
    output logic                           start,
    output logic                           operands_valid,
    input  logic                           result_ack,
    output logic                           timeout_err
);

    localparam int NELEM = DIM * DIM;
    localparam int CNT_W = $clog2(NELEM);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD_A = 2'd1;
    localparam logic [1:0] S_LOAD_B = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] elem_cnt;
    logic             byte_acc;
    logic             last_byte;
    logic             wd_fire;

    // data_ready is only ever high in a LOAD state, so this is a LOAD-state handshake
    assign byte_acc  = data_valid && data_ready;
    assign last_byte = (elem_cnt == CNT_W'(NELEM - 1));

`ifdef LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            in_load;

    assign in_load = (state == S_LOAD_A) || (state == S_LOAD_B);
    // Fires on the TIMEOUT_CYCLES-th consecutive LOAD cycle without an accepted byte
    assign wd_fire = in_load && !byte_acc && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle watchdog: restarts on every accepted byte and outside LOAD states
    always_ff @(posedge clk) begin
        if (!rst || !in_load || byte_acc || wd_fire)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_fire = 1'b0;
`endif

    // Control FSM plus operand registers; ready flags are registered from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            elem_cnt       <= '0;
            op_code        <= '0;
            scalar         <= '0;
            matrix_a       <= '0;
            matrix_b       <= '0;
            start          <= 1'b0;
            operands_valid <= 1'b0;
            cmd_err        <= 1'b0;
            timeout_err    <= 1'b0;
            cmd_ready      <= 1'b1;
            data_ready     <= 1'b0;
        end else begin
            start       <= 1'b0;
            cmd_err     <= 1'b0;
            timeout_err <= wd_fire;
            if (wd_fire) begin
                state      <= S_IDLE;
                elem_cnt   <= '0;
                matrix_a   <= '0;
                matrix_b   <= '0;
                cmd_ready  <= 1'b1;
                data_ready <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd_valid && cmd_ready) begin
                            if (cmd_op <= 3'b101) begin
                                op_code  <= cmd_op;
                                scalar   <= cmd_scalar;
                                elem_cnt <= '0;
                                // single-operand ops never load B, so clear it now
                                if (cmd_op[2:1] != 2'b00)
                                    matrix_b <= '0;
                                state      <= S_LOAD_A;
                                cmd_ready  <= 1'b0;
                                data_ready <= 1'b1;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                    S_LOAD_A: begin
                        if (byte_acc) begin
                            matrix_a[ELEM_W*int'(elem_cnt) +: ELEM_W] <= data_in;
                            if (last_byte) begin
                                elem_cnt <= '0;
                                if (op_code[2:1] == 2'b00) begin
                                    state <= S_LOAD_B;
                                end else begin
                                    state          <= S_DONE;
                                    data_ready     <= 1'b0;
                                    start          <= 1'b1;
                                    operands_valid <= 1'b1;
                                end
                            end else begin
                                elem_cnt <= elem_cnt + 1'b1;
                            end
                        end
                    end
                    S_LOAD_B: begin
                        if (byte_acc) begin
                            matrix_b[ELEM_W*int'(elem_cnt) +: ELEM_W] <= data_in;
                            if (last_byte) begin
                                elem_cnt       <= '0;
                                state          <= S_DONE;
                                data_ready     <= 1'b0;
                                start          <= 1'b1;
                                operands_valid <= 1'b1;
                            end else begin
                                elem_cnt <= elem_cnt + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (result_ack) begin
                            state          <= S_IDLE;
                            operands_valid <= 1'b0;
                            cmd_ready      <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= S_IDLE;
                        cmd_ready  <= 1'b1;
                        data_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_input_loader.sv
// Directed bench for matrix_input_loader with a scoreboard of expected operand sets.
// Build with LOADER_TIMEOUT_EN defined to include the watchdog step (TIMEOUT_CYCLES=16).
module tb_matrix_input_loader;

    localparam int ELEM_W = 8;
    localparam int DIM    = 5;
    localparam int N      = DIM * DIM;
    localparam int MW     = N * ELEM_W;
`ifdef LOADER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [7:0]        cmd_scalar;
    logic              cmd_err;
    logic              data_valid;
    logic              data_ready;
    logic [7:0]        data_in;
    logic [2:0]        op_code;
    logic [7:0]        scalar;
    logic [MW-1:0]     matrix_a;
    logic [MW-1:0]     matrix_b;
    logic              start;
    logic              operands_valid;
    logic              result_ack;
    logic              timeout_err;

    matrix_input_loader #(
        .ELEM_W(ELEM_W), .DIM(DIM), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_scalar(cmd_scalar), .cmd_err(cmd_err),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .op_code(op_code), .scalar(scalar), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .start(start), .operands_valid(operands_valid), .result_ack(result_ack),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    op;
        logic [7:0]    sc;
        logic [MW-1:0] a;
        logic [MW-1:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   start_cnt = 0;

    task automatic chkw(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every start pulse must match the oldest expected operand set
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && start === 1'b1) begin
            start_cnt++;
            chk1("sb_has_entry", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chki("sb_op_code", 32'(op_code), 32'(e.op));
                chki("sb_scalar", 32'(scalar), 32'(e.sc));
                chkw("sb_matrix_a", matrix_a, e.a);
                chkw("sb_matrix_b", matrix_b, e.b);
                chk1("sb_operands_valid", operands_valid, 1'b1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [7:0] sc,
                            input logic [MW-1:0] a, input logic [MW-1:0] b);
        exp_t e;
        e.op = op; e.sc = sc; e.a = a; e.b = b;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] sc);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_scalar = sc;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("cmd_ready_wait", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        data_valid = 1'b1; data_in = b;
        while (data_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("data_ready_wait", data_ready, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic ack();
        result_ack = 1'b1;
        chk1("ov_before_ack_edge", operands_valid, 1'b1);
        tick(1);
        result_ack = 1'b0;
        chk1("ov_after_ack", operands_valid, 1'b0);
        chk1("cmd_ready_after_ack", cmd_ready, 1'b1);
    endtask

    initial begin
        logic [MW-1:0] ea;
        logic [MW-1:0] eb;
        logic [MW-1:0] ones;
        int            n;

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_scalar = '0;
        data_valid = 1'b0; data_in = '0; result_ack = 1'b0;
        ones = '1;
        tick(3);
        rst = 1'b1;
        tick(1);

        // 1: reset in the middle of LOAD_A
        send_cmd(3'b000, 8'h11);
        for (int k = 0; k < 5; k++) send_byte(8'hA0 + 8'(k));
        chk1("t1_loading", data_ready, 1'b1);
        rst = 1'b0;
        tick(3);
        chkw("t1_matrix_a", matrix_a, '0);
        chkw("t1_matrix_b", matrix_b, '0);
        chki("t1_op_code", 32'(op_code), 32'd0);
        chki("t1_scalar", 32'(scalar), 32'd0);
        chk1("t1_start", start, 1'b0);
        chk1("t1_operands_valid", operands_valid, 1'b0);
        chk1("t1_cmd_err", cmd_err, 1'b0);
        chk1("t1_timeout_err", timeout_err, 1'b0);
        chk1("t1_data_ready", data_ready, 1'b0);
        chk1("t1_cmd_ready", cmd_ready, 1'b1);
        rst = 1'b1;
        tick(1);
        chk1("t1_cmd_ready_post", cmd_ready, 1'b1);
        chk1("t1_data_ready_post", data_ready, 1'b0);

        // 2: op 000, A = 1..25, B = all 0xFF
        for (int k = 0; k < N; k++) ea[8*k +: 8] = 8'(k + 1);
        eb = ones;
        push_exp(3'b000, 8'h00, ea, eb);
        send_cmd(3'b000, 8'h00);
        for (int k = 0; k < N; k++) send_byte(8'(k + 1));
        chk1("t2_no_start_after_a", start, 1'b0);
        chk1("t2_in_load_b", data_ready, 1'b1);
        for (int k = 0; k < N; k++) send_byte(8'hFF);
        chk1("t2_start", start, 1'b1);
        chk1("t2_ov", operands_valid, 1'b1);
        chki("t2_a_first", 32'(matrix_a[7:0]), 32'd1);
        chki("t2_a_last", 32'(matrix_a[199:192]), 32'd25);
        chkw("t2_b_ones", matrix_b, ones);
        tick(1);
        chk1("t2_start_low", start, 1'b0);
        chk1("t2_ov_held", operands_valid, 1'b1);
        chki("t2_start_once", 32'(start_cnt), 32'd1);
        ack();

        // 3: op 100 with scalar -3, A only; B must be cleared
        for (int k = 0; k < N; k++) ea[8*k +: 8] = 8'h80 + 8'(k);
        push_exp(3'b100, 8'hFD, ea, '0);
        send_cmd(3'b100, 8'hFD);
        for (int k = 0; k < N; k++) send_byte(8'h80 + 8'(k));
        chk1("t3_start", start, 1'b1);
        chk1("t3_data_ready", data_ready, 1'b0);
        chki("t3_scalar", 32'(scalar), 32'hFD);
        chkw("t3_b_zero", matrix_b, '0);
        data_valid = 1'b1; data_in = 8'h55;
        tick(3);
        data_valid = 1'b0;
        chkw("t3_a_stable", matrix_a, ea);
        chk1("t3_ov", operands_valid, 1'b1);
        chk1("t3_start_low", start, 1'b0);
        ack();

        // 4: illegal op 111 then legal op 101; stray bytes in IDLE are ignored
        data_valid = 1'b1; data_in = 8'hEE;
        send_cmd(3'b111, 8'h22);
        chk1("t4_cmd_err", cmd_err, 1'b1);
        chk1("t4_still_idle", cmd_ready, 1'b1);
        chki("t4_op_kept", 32'(op_code), 32'd4);
        chki("t4_scalar_kept", 32'(scalar), 32'hFD);
        tick(1);
        data_valid = 1'b0;
        chk1("t4_cmd_err_low", cmd_err, 1'b0);
        chkw("t4_a_untouched", matrix_a, ea);
        for (int k = 0; k < N; k++) ea[8*k +: 8] = 8'h30 + 8'(k);
        push_exp(3'b101, 8'h07, ea, '0);
        send_cmd(3'b101, 8'h07);
        for (int k = 0; k < N; k++) send_byte(8'h30 + 8'(k));
        chk1("t4_start", start, 1'b1);
        ack();

        // 5: op 001 with data_valid every other cycle, late ack
        for (int k = 0; k < N; k++) begin
            ea[8*k +: 8] = 8'(k * 7 + 3);
            eb[8*k +: 8] = 8'hC0 ^ 8'(k);
        end
        push_exp(3'b001, 8'h5A, ea, eb);
        send_cmd(3'b001, 8'h5A);
        for (int k = 0; k < 2 * N; k++) begin
            if (k > 0) begin
                data_in = 8'hEE;
                tick(1);
            end
            send_byte(k < N ? ea[8*k +: 8] : eb[8*(k-N) +: 8]);
        end
        chk1("t5_start", start, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk1("t5_ov_wait", operands_valid, 1'b1);
        end
        ack();
        chkw("t5_a_kept", matrix_a, ea);
        chkw("t5_b_kept", matrix_b, eb);
        chki("t5_op_kept", 32'(op_code), 32'd1);

        // Back-to-back command in the first IDLE cycle; op 011 clears B
        for (int k = 0; k < N; k++) ea[8*k +: 8] = 8'hF0 - 8'(k);
        push_exp(3'b011, 8'h01, ea, '0);
        send_cmd(3'b011, 8'h01);
        chk1("b2b_accepted", data_ready, 1'b1);
        chkw("b2b_b_cleared", matrix_b, '0);
        for (int k = 0; k < N; k++) send_byte(8'hF0 - 8'(k));
        chk1("b2b_start", start, 1'b1);
        ack();

`ifdef LOADER_TIMEOUT_EN
        // 6: watchdog abort after 16 idle cycles following byte 10 of A
        send_cmd(3'b000, 8'h00);
        for (int k = 0; k < 10; k++) send_byte(8'h40 + 8'(k));
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chki("t6_timeout_cycles", 32'(n), 32'd16);
        chk1("t6_timeout_err", timeout_err, 1'b1);
        chkw("t6_a_cleared", matrix_a, '0);
        chkw("t6_b_cleared", matrix_b, '0);
        chk1("t6_idle", cmd_ready, 1'b1);
        chk1("t6_data_ready", data_ready, 1'b0);
        tick(1);
        chk1("t6_pulse_low", timeout_err, 1'b0);
`else
        n = 0;
        chk1("no_timeout_err", timeout_err, 1'b0);
`endif

        tick(2);
        chki("sb_drained", 32'(sb.size()), 32'd0);
        chki("start_total", 32'(start_cnt), 32'd5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so a stuck design still produces a summary
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end

endmodule
